// File: rtl/fifo_axis_tx_pkg.sv
// rtl/fifo_axis_tx_pkg.sv - shared FSM type and buffer constants for fifo_axis_tx
//
// Purpose: holds the IDLE/RUN/DRAIN state type, the output buffer depth and
// the ring-pointer increment used by the buffer. No ports.
package fifo_axis_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int BUF_DEPTH = 3;

  // Ring pointer advance for a depth that is not a power of two.
  function automatic logic [1:0] ptr_next(input logic [1:0] p);
    return (p == 2'(BUF_DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/fifo_axis_tx_if.sv
// rtl/fifo_axis_tx_if.sv - AXI-stream style output bundle for fifo_axis_tx
//
// Purpose: groups the output stream handshake.
// Signals: tdata (DATA_WIDTH), tvalid, tready, tlast.
// Modports: master drives tdata/tvalid/tlast, slave drives tready.
interface fifo_axis_tx_if #(
  parameter int DATA_WIDTH = 16
);

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/axis_skid_buf3.sv
// rtl/axis_skid_buf3.sv - 3-entry output buffer for fifo_axis_tx
//
// Purpose: small ring buffer between the FIFO read pipeline and the stream.
// Ports:
//   clk_i, rst_n_i  clock, asynchronous active-low reset
//   push_i, data_i  write one word
//   pop_i           remove the head word (ignored when empty)
//   data_o          head word
//   occ_o           occupancy 0..3
module axis_skid_buf3
  import fifo_axis_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [1:0]            occ_o
);

  logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [1:0]            wr_ptr_q, wr_ptr_d;
  logic [1:0]            rd_ptr_q, rd_ptr_d;
  logic [1:0]            occ_q, occ_d;
  logic                  do_push, do_pop;

  assign do_pop  = pop_i && (occ_q != 2'd0);
  // A full buffer still takes a push when the head leaves in the same cycle.
  assign do_push = push_i && ((occ_q != 2'(BUF_DEPTH)) || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (do_push) wr_ptr_d = ptr_next(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_next(rd_ptr_q);
    case ({do_push, do_pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      occ_q    <= 2'd0;
    end else begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign data_o = mem_q[rd_ptr_q];
  assign occ_o  = occ_q;

endmodule

// File: rtl/fifo_axis_tx.sv
// rtl/fifo_axis_tx.sv - drains an upstream FIFO into fixed-length stream packets
//
// Purpose: reads a registered-output FIFO and emits PKT_LEN-beat packets.
// Ports:
//   rd_clk, rd_rstn   clock, asynchronous active-low reset
//   en                1 = stream, 0 = finish current packet and stop
//   fifo_empty        upstream empty flag
//   fifo_rd_en        upstream read strobe (data returns next cycle)
//   fifo_rd_data      upstream registered read data
//   m_axis            output stream (master modport)
//   busy              FSM not IDLE
//   pkt_cnt           accepted packet count, only with FIFO_AXIS_PKT_CNT_EN
module fifo_axis_tx
  import fifo_axis_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int PKT_LEN    = 256
) (
  input  logic                  rd_clk,
  input  logic                  rd_rstn,
  input  logic                  en,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  fifo_axis_tx_if.master        m_axis,
  output logic                  busy
`ifdef FIFO_AXIS_PKT_CNT_EN
  ,
  output logic [31:0]           pkt_cnt
`endif
);

  localparam int               CNT_W    = $clog2(PKT_LEN);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PKT_LEN - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             inflight_q, inflight_d;
  logic [1:0]       occ;
  logic             rd_allowed;
  logic             beat_acc;

  assign beat_acc = m_axis.tvalid && m_axis.tready;

  // The word read last cycle is on fifo_rd_data now; inflight_q is its push.
  axis_skid_buf3 #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
    .clk_i   (rd_clk),
    .rst_n_i (rd_rstn),
    .push_i  (inflight_q),
    .data_i  (fifo_rd_data),
    .pop_i   (beat_acc),
    .data_o  (m_axis.tdata),
    .occ_o   (occ)
  );

  assign m_axis.tvalid = (occ != 2'd0);
  // Beats leave in order, so the head's index is the accepted-beat count.
  assign m_axis.tlast  = m_axis.tvalid && (beat_cnt_q == LAST_IDX);

  always_comb begin
    state_d    = state_q;
    rd_cnt_d   = rd_cnt_q;
    beat_cnt_d = beat_cnt_q;
    rd_allowed = 1'b0;
    busy       = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (en) state_d = RUN;
      end
      RUN: begin
        rd_allowed = 1'b1;
        if (!en) state_d = DRAIN;
      end
      DRAIN: begin
        // Keep reading only to complete the packet already started.
        rd_allowed = (rd_cnt_q != '0);
        if (en) begin
          state_d = RUN;
        end else if ((rd_cnt_q == '0) && (occ == 2'd0) && !inflight_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Reserve a slot for the word in flight so the buffer can never overflow;
    // tready is deliberately not part of this term.
    fifo_rd_en = rd_allowed && !fifo_empty &&
                 (({1'b0, occ} + {2'b00, inflight_q}) <= 3'd2);
    inflight_d = fifo_rd_en;

    if (fifo_rd_en) rd_cnt_d = (rd_cnt_q == LAST_IDX) ? '0 : rd_cnt_q + CNT_W'(1);
    if (beat_acc)   beat_cnt_d = (beat_cnt_q == LAST_IDX) ? '0 : beat_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge rd_clk or negedge rd_rstn) begin
    if (!rd_rstn) begin
      state_q    <= IDLE;
      rd_cnt_q   <= '0;
      beat_cnt_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_cnt_q   <= rd_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      inflight_q <= inflight_d;
    end
  end

`ifdef FIFO_AXIS_PKT_CNT_EN
  logic [31:0] pkt_cnt_q;

  always_ff @(posedge rd_clk or negedge rd_rstn) begin
    if (!rd_rstn) begin
      pkt_cnt_q <= '0;
    end else if (beat_acc && m_axis.tlast) begin
      pkt_cnt_q <= pkt_cnt_q + 32'd1;
    end
  end

  assign pkt_cnt = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_axis_tx.sv
// tb/tb_fifo_axis_tx.sv - scoreboard bench for fifo_axis_tx
`timescale 1ns/1ps
module tb_fifo_axis_tx;

  localparam int DW = 16;
  localparam int PL = 4;

  logic          rd_clk      = 1'b0;
  logic          rd_rstn     = 1'b1;
  logic          en          = 1'b0;
  logic          force_empty = 1'b0;
  logic          fifo_flush  = 1'b0;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic          busy;
  logic [DW-1:0] fifo_rd_data = '0;
`ifdef FIFO_AXIS_PKT_CNT_EN
  logic [31:0]   pkt_cnt;
`endif

  fifo_axis_tx_if #(.DATA_WIDTH(DW)) axis_if ();

  fifo_axis_tx #(.DATA_WIDTH(DW), .PKT_LEN(PL)) dut (
    .rd_clk       (rd_clk),
    .rd_rstn      (rd_rstn),
    .en           (en),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .m_axis       (axis_if),
    .busy         (busy)
`ifdef FIFO_AXIS_PKT_CNT_EN
    ,
    .pkt_cnt      (pkt_cnt)
`endif
  );

  always #5 rd_clk = ~rd_clk;

  // Upstream FIFO model: registered read data, one word per strobe.
  logic [DW-1:0] fmem [256];
  int            head = 0;
  int            tail = 0;

  assign fifo_empty = force_empty || (head == tail);

  always @(posedge rd_clk) begin
    if (fifo_flush) begin
      head <= tail;
    end else if (fifo_rd_en && !fifo_empty) begin
      fifo_rd_data <= fmem[head[7:0]];
      head         <= head + 1;
    end
  end

  // Reference: every word written upstream is delivered in order; every
  // PKT_LEN-th delivered word since reset carries tlast.
  logic [DW:0] exp_q [$];
  int          push_idx  = 0;
  int          tests     = 0;
  int          fails     = 0;
  int          beats_acc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    fmem[tail[7:0]] = d;
    tail++;
    exp_q.push_back({((push_idx % PL) == PL - 1), d});
    push_idx++;
  endtask

  task automatic do_reset();
    rd_rstn        = 1'b0;
    en             = 1'b0;
    axis_if.tready = 1'b0;
    force_empty    = 1'b0;
    fifo_flush     = 1'b1;
    exp_q.delete();
    push_idx = 0;
    tick();
    tick();
    rd_rstn    = 1'b1;
    fifo_flush = 1'b0;
    tick();
  endtask

  task automatic wait_beats(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (beats_acc < target && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(beats_acc >= target), 1);
  endtask

  // Monitor: pops the scoreboard on every accepted beat and checks that a
  // stalled beat holds still.
  logic [DW:0]   e;
  bit            hold_v = 1'b0;
  logic [DW-1:0] hold_d;
  logic          hold_l;

  always @(negedge rd_clk) begin
    if (!rd_rstn) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        check("hold_tvalid", 32'(axis_if.tvalid), 1);
        check("hold_tdata", 32'(axis_if.tdata), 32'(hold_d));
        check("hold_tlast", 32'(axis_if.tlast), 32'(hold_l));
      end
      if (axis_if.tvalid && axis_if.tready) begin
        beats_acc++;
        check("beat_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("beat_tdata", 32'(axis_if.tdata), 32'(e[DW-1:0]));
          check("beat_tlast", 32'(axis_if.tlast), 32'(e[DW]));
        end
      end
      hold_v = axis_if.tvalid && !axis_if.tready;
      hold_d = axis_if.tdata;
      hold_l = axis_if.tlast;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

  initial begin
    int t_rd, t_v, f_acc, l_acc, n, base, busy_low, tlast_cyc;
    bit busy_at_last;

    axis_if.tready = 1'b0;
    #2 rd_rstn = 1'b0;
    #1;
    check("rst_fifo_rd_en", 32'(fifo_rd_en), 0);
    check("rst_tvalid", 32'(axis_if.tvalid), 0);
    check("rst_tlast", 32'(axis_if.tlast), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_tdata", 32'(axis_if.tdata), 0);
    do_reset();

    // Preloaded 1..8, always ready: latency and back-to-back delivery.
    axis_if.tready = 1'b1;
    for (int i = 1; i <= 8; i++) push_word(16'(i));
    en = 1'b1;
    t_rd = -1; t_v = -1; f_acc = -1; l_acc = -1; n = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge rd_clk);
      if (fifo_rd_en && t_rd < 0) t_rd = cyc;
      if (axis_if.tvalid && t_v < 0) t_v = cyc;
      if (axis_if.tvalid && axis_if.tready) begin
        n++;
        if (f_acc < 0) f_acc = cyc;
        l_acc = cyc;
      end
    end
    tick();
    check("t1_latency", t_v - t_rd, 2);
    check("t1_beats", n, 8);
    check("t1_back_to_back", l_acc - f_acc, 7);

    // Random backpressure over random data.
    do_reset();
    base = beats_acc;
    en = 1'b1;
    for (int i = 0; i < 24; i++) push_word(16'($urandom));
    n = 0;
    while ((beats_acc - base) < 24 && n < 800) begin
      axis_if.tready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    axis_if.tready = 1'b0;
    repeat (3) tick();
    check("t2_beats", beats_acc - base, 24);
    check("t2_exp_left", exp_q.size(), 0);

    // en drops while the second beat is handed over: first packet only.
    do_reset();
    base = beats_acc;
    axis_if.tready = 1'b1;
    for (int i = 0; i < 10; i++) push_word(16'(16'h0100 + i));
    en = 1'b1;
    n = 0; tlast_cyc = -1; busy_low = -1; busy_at_last = 1'b0;
    for (int cyc = 0; cyc < 60 && busy_low < 0; cyc++) begin
      @(negedge rd_clk);
      if (axis_if.tvalid && axis_if.tready) begin
        n++;
        if (n == 2) en = 1'b0;
        if (axis_if.tlast && tlast_cyc < 0) begin
          tlast_cyc    = cyc;
          busy_at_last = busy;
        end
      end
      if (tlast_cyc >= 0 && !busy && busy_low < 0) busy_low = cyc;
    end
    repeat (5) tick();
    check("t3_beats", beats_acc - base, 4);
    check("t3_busy_at_tlast", 32'(busy_at_last), 1);
    check("t3_busy_fall", busy_low - tlast_cyc, 2);
    check("t3_busy_end", 32'(busy), 0);
    check("t3_fifo_left", tail - head, 6);

    // Upstream empty for 5 cycles mid-packet.
    do_reset();
    base = beats_acc;
    axis_if.tready = 1'b1;
    for (int i = 0; i < 12; i++) push_word(16'(16'h0200 + i));
    en = 1'b1;
    wait_beats(base + 2, 50, "t4_reach_2");
    force_empty = 1'b1;
    tick();
    tick();
    tick();
    @(negedge rd_clk);
    check("t4_tvalid_empty_a", 32'(axis_if.tvalid), 0);
    check("t4_rd_en_empty", 32'(fifo_rd_en), 0);
    @(negedge rd_clk);
    check("t4_tvalid_empty_b", 32'(axis_if.tvalid), 0);
    tick();
    force_empty = 1'b0;
    wait_beats(base + 12, 200, "t4_reach_12");
    repeat (3) tick();
    check("t4_beats", beats_acc - base, 12);
    check("t4_exp_left", exp_q.size(), 0);

    // Reset with two words buffered, then a fresh packet from beat 0.
    do_reset();
    en = 1'b1;
    push_word(16'h0300);
    push_word(16'h0301);
    repeat (6) tick();
    check("t5_pre_tvalid", 32'(axis_if.tvalid), 1);
    #2 rd_rstn = 1'b0;
    #1;
    check("t5_rst_fifo_rd_en", 32'(fifo_rd_en), 0);
    check("t5_rst_tvalid", 32'(axis_if.tvalid), 0);
    check("t5_rst_tlast", 32'(axis_if.tlast), 0);
    check("t5_rst_busy", 32'(busy), 0);
    check("t5_rst_tdata", 32'(axis_if.tdata), 0);
    do_reset();
    base = beats_acc;
    en = 1'b1;
    axis_if.tready = 1'b1;
    for (int i = 0; i < 8; i++) push_word(16'(16'h0400 + i));
    wait_beats(base + 8, 100, "t5_reach_8");
    repeat (3) tick();
    check("t5_beats", beats_acc - base, 8);
    check("t5_exp_left", exp_q.size(), 0);

`ifdef FIFO_AXIS_PKT_CNT_EN
    // Three full packets counted.
    do_reset();
    base = beats_acc;
    en = 1'b1;
    axis_if.tready = 1'b1;
    for (int i = 0; i < 12; i++) push_word(16'($urandom));
    wait_beats(base + 12, 100, "t6_reach_12");
    repeat (3) tick();
    check("t6_pkt_cnt", pkt_cnt, 3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
